// File: rtl/bp_cfg_regfile.sv
// Tile configuration register file: queued, in-order, tagged config commands
// targeting writable registers, a sticky lock, a read-only status window and CCE ucode RAM.
module bp_cfg_regfile #(
  parameter int cfg_addr_width_p   = 16,
  parameter int reg_width_p        = 64,
  parameter int num_regs_p         = 8,
  parameter logic [num_regs_p*reg_width_p-1:0] reg_reset_vals_p = (num_regs_p*reg_width_p)'(1),
  parameter int num_ro_p           = 4,
  parameter logic [cfg_addr_width_p-1:0] ro_base_p    = 16'h0100,
  parameter logic [cfg_addr_width_p-1:0] lock_addr_p  = 16'h00FF,
  parameter logic [cfg_addr_width_p-1:0] ucode_base_p = 16'h8000,
  parameter int ucode_addr_width_p = 8,
  parameter int ucode_data_width_p = 48,
  parameter int cmd_els_p          = 4,
  parameter int resp_els_p         = 2,
  parameter int tag_width_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                cmd_v_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_w_i,
  input  logic [cfg_addr_width_p-1:0]         cmd_addr_i,
  input  logic [reg_width_p-1:0]              cmd_data_i,
  input  logic [tag_width_p-1:0]              cmd_tag_i,
  output logic                                resp_v_o,
  input  logic                                resp_yumi_i,
  output logic [reg_width_p-1:0]              resp_data_o,
  output logic [tag_width_p-1:0]              resp_tag_o,
  output logic                                resp_w_o,
  output logic                                resp_err_o,
  output logic [num_regs_p*reg_width_p-1:0]   reg_data_o,
  output logic                                locked_o,
  input  logic [num_ro_p*reg_width_p-1:0]     ro_data_i,
  output logic                                ucode_v_o,
  output logic                                ucode_w_o,
  output logic [ucode_addr_width_p-1:0]       ucode_addr_o,
  output logic [ucode_data_width_p-1:0]       ucode_data_o,
  input  logic [ucode_data_width_p-1:0]       ucode_data_i
);

  localparam int CPW = (cmd_els_p > 1) ? $clog2(cmd_els_p) : 1;
  localparam int CCW = $clog2(cmd_els_p + 1);
  localparam int RPW = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int RCW = $clog2(resp_els_p + 1);

  typedef struct packed {
    logic                        w;
    logic [cfg_addr_width_p-1:0] addr;
    logic [reg_width_p-1:0]      data;
    logic [tag_width_p-1:0]      tag;
  } cmd_t;

  typedef struct packed {
    logic [reg_width_p-1:0] data;
    logic [tag_width_p-1:0] tag;
    logic                   w;
    logic                   err;
  } resp_t;

  cmd_t                    cmd_mem [cmd_els_p];
  logic [CPW-1:0]          cmd_wptr, cmd_rptr;
  logic [CCW-1:0]          cmd_cnt, cmd_cnt_next;
  logic                    cmd_ready_q, cmd_enq;

  resp_t                   resp_mem [resp_els_p];
  logic [RPW-1:0]          resp_wptr, resp_rptr;
  logic [RCW-1:0]          resp_cnt;
  logic                    resp_enq, resp_deq;
  resp_t                   resp_in, issue_resp;

  logic                    infl_v_q, infl_w_q;
  logic [tag_width_p-1:0]  infl_tag_q;

  logic [num_regs_p*reg_width_p-1:0] regs_q;
  logic                    lock_q;

  cmd_t                    head;
  logic                    is_ucode, is_lock, is_reg, is_ro;
  logic [num_regs_p-1:0]   reg_sel;
  logic [reg_width_p-1:0]  reg_rdata, ro_rdata;
  logic                    hit_reg, hit_ro, credit_ok, issue, reg_we;
  logic [RCW:0]            credit_used;

  function automatic logic [CPW-1:0] cmd_ptr_inc(input logic [CPW-1:0] p);
    return (p == CPW'(cmd_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RPW-1:0] resp_ptr_inc(input logic [RPW-1:0] p);
    return (p == RPW'(resp_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready_o  = cmd_ready_q & reset_n_i;
  assign cmd_enq      = cmd_v_i & cmd_ready_o;
  assign cmd_cnt_next = cmd_cnt + CCW'(cmd_enq) - CCW'(issue);
  assign head         = cmd_mem[cmd_rptr];

  always_ff @(posedge clk_i) begin
    if (cmd_enq) cmd_mem[cmd_wptr] <= '{cmd_w_i, cmd_addr_i, cmd_data_i, cmd_tag_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cmd_wptr    <= '0;
      cmd_rptr    <= '0;
      cmd_cnt     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (cmd_enq) cmd_wptr <= cmd_ptr_inc(cmd_wptr);
      if (issue)   cmd_rptr <= cmd_ptr_inc(cmd_rptr);
      cmd_cnt     <= cmd_cnt_next;
      cmd_ready_q <= (cmd_cnt_next != CCW'(cmd_els_p));
    end
  end

  // First match wins: ucode, lock, register, read-only, else unmapped.
  always_comb begin
    reg_sel   = '0;
    reg_rdata = '0;
    ro_rdata  = '0;
    hit_reg   = 1'b0;
    hit_ro    = 1'b0;
    for (int i = 0; i < num_regs_p; i++) begin
      if (head.addr == cfg_addr_width_p'(i)) begin
        hit_reg    = 1'b1;
        reg_sel[i] = 1'b1;
        reg_rdata  = regs_q[i*reg_width_p +: reg_width_p];
      end
    end
    for (int i = 0; i < num_ro_p; i++) begin
      if (head.addr == ro_base_p + cfg_addr_width_p'(i)) begin
        hit_ro   = 1'b1;
        ro_rdata = ro_data_i[i*reg_width_p +: reg_width_p];
      end
    end
    is_ucode = (head.addr >= ucode_base_p);
    is_lock  = !is_ucode && (head.addr == lock_addr_p);
    is_reg   = !is_ucode && !is_lock && hit_reg;
    is_ro    = !is_ucode && !is_lock && !hit_reg && hit_ro;
  end

  // A pending ucode completion owns the response enqueue, so only another ucode may issue behind it.
  assign credit_used = {1'b0, resp_cnt} + (RCW+1)'(infl_v_q);
  assign credit_ok   = credit_used < (RCW+1)'(resp_els_p);
  assign issue       = reset_n_i && (cmd_cnt != '0) && credit_ok && !(infl_v_q && !is_ucode);
  assign reg_we      = issue && is_reg && head.w && !lock_q;

  assign ucode_v_o    = issue && is_ucode;
  assign ucode_w_o    = ucode_v_o && head.w;
  assign ucode_addr_o = head.addr[ucode_addr_width_p-1:0];
  assign ucode_data_o = head.data[ucode_data_width_p-1:0];

  always_comb begin
    issue_resp.data = '0;
    issue_resp.tag  = head.tag;
    issue_resp.w    = head.w;
    issue_resp.err  = 1'b1;
    if (is_lock) begin
      issue_resp.err = 1'b0;
      if (!head.w) issue_resp.data = {{(reg_width_p-1){1'b0}}, lock_q};
    end else if (is_reg) begin
      issue_resp.err = head.w && lock_q;
      if (!head.w) issue_resp.data = reg_rdata;
    end else if (is_ro) begin
      issue_resp.err = head.w;
      if (!head.w) issue_resp.data = ro_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      regs_q <= reg_reset_vals_p;
      lock_q <= 1'b0;
    end else begin
      for (int i = 0; i < num_regs_p; i++) begin
        if (reg_we && reg_sel[i]) regs_q[i*reg_width_p +: reg_width_p] <= head.data;
      end
      if (issue && is_lock && head.w && head.data[0]) lock_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      infl_v_q   <= 1'b0;
      infl_w_q   <= 1'b0;
      infl_tag_q <= '0;
    end else begin
      infl_v_q   <= issue && is_ucode;
      infl_w_q   <= head.w;
      infl_tag_q <= head.tag;
    end
  end

  always_comb begin
    resp_enq = infl_v_q || (issue && !is_ucode);
    resp_in  = issue_resp;
    if (infl_v_q) begin
      resp_in.data = infl_w_q ? '0 : reg_width_p'(ucode_data_i);
      resp_in.tag  = infl_tag_q;
      resp_in.w    = infl_w_q;
      resp_in.err  = 1'b0;
    end
  end

  assign resp_deq = resp_yumi_i && (resp_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (resp_enq) resp_mem[resp_wptr] <= resp_in;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_wptr <= '0;
      resp_rptr <= '0;
      resp_cnt  <= '0;
    end else begin
      if (resp_enq) resp_wptr <= resp_ptr_inc(resp_wptr);
      if (resp_deq) resp_rptr <= resp_ptr_inc(resp_rptr);
      resp_cnt <= resp_cnt + RCW'(resp_enq) - RCW'(resp_deq);
    end
  end

  assign resp_v_o    = reset_n_i && (resp_cnt != '0);
  assign resp_data_o = resp_mem[resp_rptr].data;
  assign resp_tag_o  = resp_mem[resp_rptr].tag;
  assign resp_w_o    = resp_mem[resp_rptr].w;
  assign resp_err_o  = resp_mem[resp_rptr].err;
  assign reg_data_o  = regs_q;
  assign locked_o    = lock_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                     resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_bp_cfg_regfile.sv
// Directed self-checking bench for bp_cfg_regfile with a small ucode RAM model
// and a response collector.
module tb_bp_cfg_regfile;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_v, cmd_ready, cmd_w;
  logic [15:0]  cmd_addr;
  logic [63:0]  cmd_data;
  logic [3:0]   cmd_tag;
  logic         resp_v, resp_yumi, resp_w, resp_err;
  logic [63:0]  resp_data;
  logic [3:0]   resp_tag;
  logic [511:0] reg_data;
  logic         locked;
  logic [255:0] ro_data;
  logic         ucode_v, ucode_w;
  logic [7:0]   ucode_addr;
  logic [47:0]  ucode_wdata, ucode_rdata;
  logic         yumi_en;

  int tests_run = 0;
  int fail_count = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        w;
    logic        err;
  } rx_t;

  rx_t         rx_q[$];
  logic [47:0] ucode_mem [256];
  int          uc_wr_count = 0;
  logic [7:0]  uc_wr_addr;
  logic [47:0] uc_wr_data;

  always #5 clk = ~clk;

  assign resp_yumi = yumi_en & resp_v;

  bp_cfg_regfile dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_w_i(cmd_w),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_tag_i(cmd_tag),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data),
    .resp_tag_o(resp_tag), .resp_w_o(resp_w), .resp_err_o(resp_err),
    .reg_data_o(reg_data), .locked_o(locked), .ro_data_i(ro_data),
    .ucode_v_o(ucode_v), .ucode_w_o(ucode_w), .ucode_addr_o(ucode_addr),
    .ucode_data_o(ucode_wdata), .ucode_data_i(ucode_rdata)
  );

  // Synchronous-read ucode RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ucode_v) begin
      if (ucode_w) ucode_mem[ucode_addr] <= ucode_wdata;
      else         ucode_rdata <= ucode_mem[ucode_addr];
    end
  end

  always @(negedge clk) begin
    if (resp_v && resp_yumi) rx_q.push_back('{resp_data, resp_tag, resp_w, resp_err});
    if (ucode_v && ucode_w) begin
      uc_wr_count++;
      uc_wr_addr = ucode_addr;
      uc_wr_data = ucode_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic applyStimulus(input logic w, input logic [15:0] addr, input logic [63:0] data,
                               input logic [3:0] tag);
    int wait_cycles = 0;
    cmd_w = w; cmd_addr = addr; cmd_data = data; cmd_tag = tag; cmd_v = 1'b1;
    @(negedge clk);
    while (!cmd_ready && wait_cycles < 100) begin
      wait_cycles++;
      @(negedge clk);
    end
    if (!cmd_ready) checkOutput("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_v = 1'b0;
  endtask

  task automatic wait_resps(input int n);
    int cycles = 0;
    while (rx_q.size() < n && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (rx_q.size() < n) checkOutput("resp_wait_timeout", 64'(rx_q.size()), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_resp(input string name, input int idx, input logic [3:0] tag,
                            input logic w, input logic err, input logic [63:0] data);
    if (idx >= rx_q.size()) begin
      checkOutput({name, ".present"}, 64'(rx_q.size()), 64'(idx + 1));
      return;
    end
    checkOutput({name, ".tag"}, 64'(rx_q[idx].tag), 64'(tag));
    checkOutput({name, ".w"}, 64'(rx_q[idx].w), 64'(w));
    checkOutput({name, ".err"}, 64'(rx_q[idx].err), 64'(err));
    checkOutput({name, ".data"}, rx_q[idx].data, data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rx_before;
    logic [15:0] burst_addr [6];
    logic [63:0] burst_exp  [6];
    burst_addr = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    burst_exp  = '{64'd1, 64'd0, 64'hDEAD, 64'd0, 64'd0, 64'd0};

    reset_n = 1'b0; cmd_v = 1'b0; cmd_w = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_tag = '0;
    yumi_en = 1'b0;
    ro_data = {64'hC3, 64'hB2, 64'h7, 64'hA0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_held.cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_held.resp_v", 64'(resp_v), 64'd0);
    checkOutput("rst_held.ucode_v", 64'(ucode_v), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rel.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_rel.freeze", reg_data[63:0], 64'd1);
    checkOutput("rst_rel.reg1", reg_data[127:64], 64'd0);
    checkOutput("rst_rel.reg7", reg_data[511:448], 64'd0);
    checkOutput("rst_rel.locked", 64'(locked), 64'd0);
    checkOutput("rst_rel.resp_v", 64'(resp_v), 64'd0);
    @(posedge clk); #1;

    // Write followed immediately by read of the same register
    yumi_en = 1'b1;
    base = rx_q.size();
    applyStimulus(1'b1, 16'd2, 64'hDEAD, 4'd3);
    applyStimulus(1'b0, 16'd2, 64'd0, 4'd4);
    wait_resps(base + 2);
    check_resp("wr_rd.wr", base, 4'd3, 1'b1, 1'b0, 64'd0);
    check_resp("wr_rd.rd", base + 1, 4'd4, 1'b0, 1'b0, 64'hDEAD);
    checkOutput("wr_rd.reg2", reg_data[191:128], 64'hDEAD);

    // Back-pressure: 2 responses held plus 4 queued commands
    yumi_en = 1'b0;
    base = rx_q.size();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, burst_addr[i], 64'd0, 4'(5 + i));
    @(negedge clk);
    checkOutput("bp.cmd_ready_full", 64'(cmd_ready), 64'd0);
    checkOutput("bp.resp_v_held", 64'(resp_v), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("bp.no_rx_while_stalled", 64'(rx_q.size()), 64'(base));
    @(posedge clk); #1;
    yumi_en = 1'b1;
    wait_resps(base + 6);
    for (int i = 0; i < 6; i++)
      check_resp($sformatf("bp.r%0d", i), base + i, 4'(5 + i), 1'b0, 1'b0, burst_exp[i]);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp.no_dup", 64'(rx_q.size()), 64'(base + 6));

    // Lock, rejected freeze write, ucode write/read, lock readback
    base = rx_q.size();
    applyStimulus(1'b1, 16'h00FF, 64'd1, 4'd1);
    applyStimulus(1'b1, 16'h0000, 64'd0, 4'd2);
    applyStimulus(1'b1, 16'h8005, 64'h123, 4'd3);
    wait_resps(base + 3);
    checkOutput("uc_wr.count", 64'(uc_wr_count), 64'd1);
    checkOutput("uc_wr.addr", 64'(uc_wr_addr), 64'd5);
    checkOutput("uc_wr.data", 64'(uc_wr_data), 64'h123);
    applyStimulus(1'b0, 16'h8005, 64'd0, 4'd4);
    applyStimulus(1'b0, 16'h00FF, 64'd0, 4'd5);
    wait_resps(base + 5);
    check_resp("lock.wr", base, 4'd1, 1'b1, 1'b0, 64'd0);
    check_resp("lock.freeze_wr", base + 1, 4'd2, 1'b1, 1'b1, 64'd0);
    check_resp("uc.wr", base + 2, 4'd3, 1'b1, 1'b0, 64'd0);
    check_resp("uc.rd", base + 3, 4'd4, 1'b0, 1'b0, 64'h123);
    check_resp("lock.rd", base + 4, 4'd5, 1'b0, 1'b0, 64'd1);
    checkOutput("lock.freeze_kept", reg_data[63:0], 64'd1);
    checkOutput("lock.locked", 64'(locked), 64'd1);

    // Read-only window edges, unmapped holes, last register
    base = rx_q.size();
    applyStimulus(1'b0, 16'h0101, 64'd0, 4'd6);
    applyStimulus(1'b0, 16'h0103, 64'd0, 4'd7);
    applyStimulus(1'b0, 16'h0104, 64'd0, 4'd8);
    applyStimulus(1'b0, 16'h0040, 64'd0, 4'd9);
    applyStimulus(1'b1, 16'h0100, 64'hFFFF, 4'd10);
    applyStimulus(1'b0, 16'h0007, 64'd0, 4'd11);
    applyStimulus(1'b0, 16'h0008, 64'd0, 4'd12);
    wait_resps(base + 7);
    check_resp("ro.slice1", base, 4'd6, 1'b0, 1'b0, 64'h7);
    check_resp("ro.slice3", base + 1, 4'd7, 1'b0, 1'b0, 64'hC3);
    check_resp("ro.past_end", base + 2, 4'd8, 1'b0, 1'b1, 64'd0);
    check_resp("unmapped.rd", base + 3, 4'd9, 1'b0, 1'b1, 64'd0);
    check_resp("ro.wr", base + 4, 4'd10, 1'b1, 1'b1, 64'd0);
    check_resp("reg.last", base + 5, 4'd11, 1'b0, 1'b0, 64'd0);
    check_resp("reg.past_end", base + 6, 4'd12, 1'b0, 1'b1, 64'd0);

    // Reset while 3 commands queued and a ucode read is in flight
    yumi_en = 1'b0;
    base = rx_q.size();
    applyStimulus(1'b0, 16'h0001, 64'd0, 4'd1);
    applyStimulus(1'b0, 16'h0003, 64'd0, 4'd2);
    applyStimulus(1'b0, 16'h8005, 64'd0, 4'd3);
    applyStimulus(1'b0, 16'h0000, 64'd0, 4'd4);
    applyStimulus(1'b0, 16'h0001, 64'd0, 4'd5);
    applyStimulus(1'b0, 16'h0002, 64'd0, 4'd6);
    yumi_en = 1'b1;
    @(posedge clk); #1;
    yumi_en = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst.uc_strobe", 64'(ucode_v), 64'd1);
    checkOutput("mid_rst.uc_read", 64'(ucode_w), 64'd0);
    checkOutput("mid_rst.uc_addr", 64'(ucode_addr), 64'd5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    rx_before = rx_q.size();
    checkOutput("mid_rst.one_popped", 64'(rx_before), 64'(base + 1));
    @(negedge clk);
    checkOutput("mid_rst.resp_v", 64'(resp_v), 64'd0);
    checkOutput("mid_rst.cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("mid_rst.ucode_v", 64'(ucode_v), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    yumi_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_rst.locked", 64'(locked), 64'd0);
    checkOutput("post_rst.freeze", reg_data[63:0], 64'd1);
    checkOutput("post_rst.reg2", reg_data[191:128], 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("post_rst.no_stale_resp", 64'(rx_q.size()), 64'(rx_before));
    checkOutput("post_rst.resp_v", 64'(resp_v), 64'd0);
    @(posedge clk); #1;
    base = rx_q.size();
    applyStimulus(1'b0, 16'h0000, 64'd0, 4'd13);
    applyStimulus(1'b1, 16'h0000, 64'd0, 4'd14);
    wait_resps(base + 2);
    check_resp("post_rst.rd0", base, 4'd13, 1'b0, 1'b0, 64'd1);
    check_resp("post_rst.wr0", base + 1, 4'd14, 1'b1, 1'b0, 64'd0);
    checkOutput("post_rst.freeze_cleared", reg_data[63:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
